// File: rtl/mem_word_arbiter_if.sv
// Requester (fetch/data) and byte-wide memory signals bundled for the word arbiter.
// The arbiter takes the slave side; requesters and the memory model take the master side.
interface mem_word_arbiter_if;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_size;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        busy;
  logic [15:0] mem_address;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_cs;
  logic [7:0]  mem_out;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_out,
    output f_ack, f_rdata, d_ack, d_rdata, busy, mem_address, mem_data, mem_wr, mem_cs
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_out,
    input  f_ack, f_rdata, d_ack, d_rdata, busy, mem_address, mem_data, mem_wr, mem_cs
  );
endinterface

// File: rtl/mem_word_arbiter.sv
// Arbitrates fetch and data ports onto a byte-wide memory, splitting words into two
// little-endian byte accesses.
//  state | meaning
//  IDLE  | no transfer; grant a pending request and latch its fields
//  BYTE0 | access byte at A (low byte)
//  BYTE1 | access byte at A+1 (high byte, word transfers only)
//  RESP  | one-cycle Ack to the owner; its RData already updated
module mem_word_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_word_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BYTE0 = 2'd1,
    S_BYTE1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic        r_word;
  logic        r_owner_d;
  logic        r_rr_d;
  logic [7:0]  r_lo;
  logic [15:0] r_f_rdata;
  logic [15:0] r_d_rdata;

  logic        w_any_req;
  logic        w_grant_d;
  logic [15:0] w_mem_address;
  logic [7:0]  w_mem_data;
  logic        w_mem_wr;
  logic        w_mem_cs;

  // D wins when it is the only requester, or on a tie when priority or the pointer favours it
  assign w_any_req = io_bus.f_req | io_bus.d_req;
  assign w_grant_d = io_bus.d_req & (~io_bus.f_req | FIXED_PRIO | r_rr_d);

  always_comb begin
    w_next        = r_state;
    w_mem_address = 16'h0000;
    w_mem_data    = 8'h00;
    w_mem_wr      = 1'b0;
    w_mem_cs      = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_BYTE0;
      end
      S_BYTE0: begin
        w_mem_address = r_addr;
        w_mem_data    = r_wdata[7:0];
        w_mem_wr      = r_we;
        w_mem_cs      = 1'b0;
        w_next        = r_word ? S_BYTE1 : S_RESP;
      end
      S_BYTE1: begin
        w_mem_address = r_addr + 16'd1;
        w_mem_data    = r_wdata[15:8];
        w_mem_wr      = r_we;
        w_mem_cs      = 1'b0;
        w_next        = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_we      <= 1'b0;
      r_word    <= 1'b0;
      r_owner_d <= 1'b0;
      r_rr_d    <= 1'b0;
      r_lo      <= 8'h00;
      r_f_rdata <= 16'h0000;
      r_d_rdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            r_rr_d    <= ~r_rr_d;
            if (w_grant_d) begin
              r_addr  <= io_bus.d_addr;
              r_wdata <= io_bus.d_wdata;
              r_we    <= io_bus.d_we;
              r_word  <= io_bus.d_size;
            end else begin
              r_addr  <= io_bus.f_addr;
              r_wdata <= 16'h0000;
              r_we    <= 1'b0;
              r_word  <= 1'b1;
            end
          end
        end
        S_BYTE0: begin
          r_lo <= io_bus.mem_out;
          // fetches are always words, so a byte read here can only belong to D
          if (!r_word && !r_we) r_d_rdata <= {8'h00, io_bus.mem_out};
        end
        S_BYTE1: begin
          if (!r_we) begin
            if (r_owner_d) r_d_rdata <= {io_bus.mem_out, r_lo};
            else           r_f_rdata <= {io_bus.mem_out, r_lo};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.f_ack       = (r_state == S_RESP) & ~r_owner_d;
  assign io_bus.d_ack       = (r_state == S_RESP) &  r_owner_d;
  assign io_bus.f_rdata     = r_f_rdata;
  assign io_bus.d_rdata     = r_d_rdata;
  assign io_bus.busy        = (r_state != S_IDLE);
  assign io_bus.mem_address = w_mem_address;
  assign io_bus.mem_data    = w_mem_data;
  assign io_bus.mem_wr      = w_mem_wr;
  assign io_bus.mem_cs      = w_mem_cs;

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Bench for mem_word_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grant order, latency and memory contents.
module tb_mem_word_arbiter;

  logic clk;
  logic rst0;
  logic rst1;
  int   cyc;
  int   errors;
  int   checks;

  mem_word_arbiter_if b0 ();
  mem_word_arbiter_if b1 ();

  mem_word_arbiter #(.FIXED_PRIO(1'b0)) u_dut0 (.i_clk(clk), .i_rst(rst0), .io_bus(b0));
  mem_word_arbiter #(.FIXED_PRIO(1'b1)) u_dut1 (.i_clk(clk), .i_rst(rst1), .io_bus(b1));

  logic [7:0]  mem0 [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_a;
  logic [7:0]  ld_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // byte memory: async read, write at the clock edge while CS=0 and WR=1
  always @(posedge clk) begin
    if (ld_en) mem0[ld_a] <= ld_d;
    else if (!b0.mem_cs && b0.mem_wr) mem0[b0.mem_address] <= b0.mem_data;
  end
  assign b0.mem_out = mem0[b0.mem_address];
  assign b1.mem_out = 8'h5A;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic f_xfer(input logic [15:0] a, output logic [15:0] rd, output int lat,
                        output int cs_cnt, output logic [15:0] a0, output logic [15:0] a1);
    int c;
    bit got;
    @(negedge clk);
    b0.f_req = 1'b1; b0.f_addr = a;
    c = cyc; got = 0; cs_cnt = 0; a0 = '0; a1 = '0; lat = 0; rd = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!b0.mem_cs) begin
        if (cs_cnt == 0) a0 = b0.mem_address; else a1 = b0.mem_address;
        cs_cnt++;
      end
      if (b0.f_ack) begin
        got = 1; lat = cyc - c; rd = b0.f_rdata; b0.f_req = 1'b0;
      end
    end
    if (!got) begin
      chk("f_ack_timeout", 0, 1);
      b0.f_req = 1'b0;
    end
  endtask

  task automatic d_xfer(input logic we, input logic sz, input logic [15:0] a, input logic [15:0] wd,
                        input bit chg, input logic [15:0] chg_a,
                        output logic [15:0] rd, output int lat);
    int c;
    bit got;
    @(negedge clk);
    b0.d_req = 1'b1; b0.d_we = we; b0.d_size = sz; b0.d_addr = a; b0.d_wdata = wd;
    c = cyc; got = 0; lat = 0; rd = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (chg && i == 0) begin
        b0.d_addr = chg_a; b0.d_wdata = ~wd; b0.d_we = ~we;
      end
      if (b0.d_ack) begin
        got = 1; lat = cyc - c; rd = b0.d_rdata; b0.d_req = 1'b0;
      end
    end
    if (!got) begin
      chk("d_ack_timeout", 0, 1);
      b0.d_req = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] a;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      a = 16'hFFFF;
    else if (r == 1) a = 16'hFFFE;
    else             a = 16'h0100 + 16'($urandom_range(0, 30));
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, a0, a1, fa, da, dwd, exp_f, exp_d, a_hi;
    int          lat, cs_cnt, n, fcnt, dcnt, f_lat, d_lat, exp_fl, exp_dl, ld;
    logic [3:0]  seqv;
    logic        dwe, dsz, d_first, use_f, use_d, model_rr;
    logic [15:0] f_rd_seen, d_rd_seen;

    errors = 0; checks = 0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;
    rst0 = 1'b1; rst1 = 1'b1;
    b0.f_req = 0; b0.f_addr = '0; b0.d_req = 0; b0.d_we = 0; b0.d_size = 0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.f_req = 0; b1.f_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_size = 0; b1.d_addr = '0; b1.d_wdata = '0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    chk("rst_busy", b0.busy, 0);
    chk("rst_cs", b0.mem_cs, 1);
    chk("rst_wr", b0.mem_wr, 0);
    chk("rst_addr", b0.mem_address, 0);
    chk("rst_acks", {b0.f_ack, b0.d_ack}, 0);
    chk("rst_rdata", {b0.f_rdata, b0.d_rdata}, 0);

    // fetch word from preloaded memory
    poke(16'h0100, 8'h34);
    poke(16'h0101, 8'h12);
    f_xfer(16'h0100, rd, lat, cs_cnt, a0, a1);
    chk("f_data", rd, 16'h1234);
    chk("f_lat", lat, 3);
    chk("f_cs_cycles", cs_cnt, 2);
    chk("f_addr0", a0, 16'h0100);
    chk("f_addr1", a1, 16'h0101);

    // word write then byte read of the high byte
    d_xfer(1, 1, 16'h0200, 16'hBEEF, 0, '0, rd, lat);
    chk("dw_lat", lat, 3);
    chk("dw_mem_lo", mem0[16'h0200], 8'hEF);
    chk("dw_mem_hi", mem0[16'h0201], 8'hBE);
    d_xfer(0, 0, 16'h0201, 16'h0000, 0, '0, rd, lat);
    chk("db_data", rd, 16'h00BE);
    chk("db_lat", lat, 2);

    // address wrap on the high byte
    d_xfer(1, 1, 16'hFFFF, 16'hA55A, 0, '0, rd, lat);
    chk("wrap_lo", mem0[16'hFFFF], 8'h5A);
    chk("wrap_hi", mem0[16'h0000], 8'hA5);

    // fields changed while busy are ignored
    poke(16'h0400, 8'h99);
    poke(16'h0401, 8'h88);
    d_xfer(0, 1, 16'h0100, 16'h0000, 1, 16'h0400, rd, lat);
    chk("hold_data", rd, 16'h1234);
    chk("hold_mem", {mem0[16'h0401], mem0[16'h0400]}, 16'h8899);

    // reset during BYTE0 of a word write
    poke(16'h0300, 8'h00);
    poke(16'h0301, 8'h5C);
    @(negedge clk);
    b0.d_req = 1; b0.d_we = 1; b0.d_size = 1; b0.d_addr = 16'h0300; b0.d_wdata = 16'h7788;
    @(negedge clk);
    chk("mid_cs_low", b0.mem_cs, 0);
    rst0 = 1'b1; b0.d_req = 0;
    @(negedge clk);
    rst0 = 1'b0;
    chk("mid_busy", b0.busy, 0);
    chk("mid_cs", b0.mem_cs, 1);
    chk("mid_bus", {b0.mem_wr, b0.mem_address, b0.mem_data}, 0);
    chk("mid_acks", {b0.f_ack, b0.d_ack}, 0);
    chk("mid_rdata", {b0.f_rdata, b0.d_rdata}, 0);
    chk("mid_mem_lo", mem0[16'h0300], 8'h88);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b0.d_ack || !b0.mem_cs) n++;
    end
    chk("mid_no_activity", n, 0);
    chk("mid_mem_hi", mem0[16'h0301], 8'h5C);
    ref_mem[16'h0300] = 8'h88;

    // round-robin with both requests held, pointer starts at F after reset
    @(negedge clk);
    b0.f_req = 1; b0.f_addr = 16'h0100;
    b0.d_req = 1; b0.d_we = 0; b0.d_size = 0; b0.d_addr = 16'h0201;
    n = 0; seqv = '0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (b0.f_ack) begin seqv = {seqv[2:0], 1'b0}; n++; end
      if (b0.d_ack) begin seqv = {seqv[2:0], 1'b1}; n++; end
    end
    b0.f_req = 0; b0.d_req = 0;
    chk("rr_count", n, 4);
    chk("rr_order", seqv, 4'b0101);
    @(negedge clk);

    // fixed priority: D starves F until D drops
    @(negedge clk);
    b1.f_req = 1; b1.f_addr = 16'h0010;
    b1.d_req = 1; b1.d_we = 0; b1.d_size = 0; b1.d_addr = 16'h0020;
    fcnt = 0; dcnt = 0;
    for (int i = 0; i < 40 && dcnt < 3; i++) begin
      @(negedge clk);
      if (b1.f_ack) fcnt++;
      if (b1.d_ack) dcnt++;
    end
    b1.d_req = 0;
    chk("fix_d_count", dcnt, 3);
    chk("fix_f_starved", fcnt, 0);
    for (int i = 0; i < 20 && fcnt == 0; i++) begin
      @(negedge clk);
      if (b1.f_ack) fcnt++;
    end
    b1.f_req = 0;
    chk("fix_f_after", fcnt, 1);

    // random traffic against the transaction model
    for (int a = 16'h0100; a <= 16'h011F; a++) poke(16'(a), 8'($urandom));
    poke(16'hFFFE, 8'($urandom));
    poke(16'hFFFF, 8'($urandom));
    poke(16'h0000, 8'($urandom));
    model_rr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 2);
      use_f = (n != 1);
      use_d = (n != 0);
      fa = pick_addr(); da = pick_addr();
      dwe = 1'($urandom); dsz = 1'($urandom); dwd = 16'($urandom);
      ld = dsz ? 3 : 2;
      d_first = use_d && (!use_f || model_rr);
      if (use_f) model_rr = ~model_rr;
      if (use_d) model_rr = ~model_rr;
      exp_fl = 0; exp_dl = 0; exp_f = '0; exp_d = '0;
      if (use_f && use_d) begin
        if (d_first) begin exp_dl = ld; exp_fl = ld + 1 + 3; end
        else         begin exp_fl = 3;  exp_dl = 3 + 1 + ld; end
      end else begin
        exp_fl = 3; exp_dl = ld;
      end
      a_hi = da + 16'd1;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0) == d_first) begin
          if (use_d) begin
            if (dwe) begin
              ref_mem[da] = dwd[7:0];
              if (dsz) ref_mem[a_hi] = dwd[15:8];
            end else begin
              exp_d = dsz ? {ref_mem[a_hi], ref_mem[da]} : {8'h00, ref_mem[da]};
            end
          end
        end else if (use_f) begin
          exp_f = {ref_mem[fa + 16'd1], ref_mem[fa]};
        end
      end

      @(negedge clk);
      n = cyc;
      if (use_f) begin b0.f_req = 1; b0.f_addr = fa; end
      if (use_d) begin
        b0.d_req = 1; b0.d_we = dwe; b0.d_size = dsz; b0.d_addr = da; b0.d_wdata = dwd;
      end
      fcnt = 0; dcnt = 0; f_lat = -1; d_lat = -1; f_rd_seen = '0; d_rd_seen = '0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (b0.f_ack) begin fcnt++; f_lat = cyc - n; f_rd_seen = b0.f_rdata; b0.f_req = 0; end
        if (b0.d_ack) begin dcnt++; d_lat = cyc - n; d_rd_seen = b0.d_rdata; b0.d_req = 0; end
      end
      b0.f_req = 0; b0.d_req = 0;
      chk("rnd_f_acks", fcnt, 32'(use_f));
      chk("rnd_d_acks", dcnt, 32'(use_d));
      if (use_f) begin
        chk("rnd_f_lat", f_lat, exp_fl);
        chk("rnd_f_data", f_rd_seen, exp_f);
      end
      if (use_d) begin
        chk("rnd_d_lat", d_lat, exp_dl);
        if (!dwe) chk("rnd_d_data", d_rd_seen, exp_d);
        else begin
          chk("rnd_wr_lo", mem0[da], ref_mem[da]);
          if (dsz) chk("rnd_wr_hi", mem0[a_hi], ref_mem[a_hi]);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
